// File: rtl/zmips_regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zmips_regfile_mp_pkg
// Purpose  : Shared constants and state encoding for the multi-port zMIPS
//            register file and its read-port slices.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package zmips_regfile_mp_pkg;

  localparam int ZMIPS_XLEN     = 32;
  localparam int ZMIPS_NREG     = 32;
  localparam int ZMIPS_LINK_REG = 31;

  // Sweep FSM: CLEAR zeroes one entry per cycle, READY accepts writes.
  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

endpackage : zmips_regfile_mp_pkg
`default_nettype wire

// File: rtl/zmips_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module   : zmips_regfile_rdport
// Purpose  : One read port of the zMIPS register file. Applies the zero
//            register, out-of-range and clear-sweep masking, then the optional
//            same-cycle bypass from the link and general write ports.
// Ports    : clearing          - file is sweeping (or held in reset)
//            addr              - read address
//            stored            - array contents at addr
//            wr/wr_addr/wr_data- general write port (for bypass)
//            pc_wr/pc_val      - link write port (for bypass)
//            data              - resolved read data
// Revision : 1.0 - initial release
// ============================================================================
module zmips_regfile_rdport #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic          clearing,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  stored,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          pc_wr,
  input  logic [W-1:0]  pc_val,
  output logic [W-1:0]  data
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic w_in_range;

  // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
  assign w_in_range = ({1'b0, addr} < (AW+1)'(DEPTH));

  // Link bypass outranks the general bypass so that a read of LINK_REG sees
  // the same winner that the array will store.
  always_comb begin
    data = stored;
    if (clearing || (addr == '0) || !w_in_range) begin
      data = '0;
    end else if ((BYPASS != 0) && pc_wr && (addr == LINK_A)) begin
      data = pc_val;
    end else if ((BYPASS != 0) && wr && (addr == wr_addr)) begin
      data = wr_data;
    end
  end

endmodule : zmips_regfile_rdport
`default_nettype wire

// File: rtl/zmips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : zmips_regfile_mp
// Purpose  : Parametrised multi-read-port register file for the zMIPS core.
//            NRD combinational read ports, a general write port, a dedicated
//            link write port (pc_wr -> LINK_REG), hardwired zero register,
//            optional write-to-read bypass and a one-entry-per-cycle clear
//            sweep after reset or on a clr pulse.
// Ports    : clk, rst_n (async, active low), clr (restart clear sweep)
//            rd_addr[NRD*AW], rd_data[NRD*W]  - read ports, port k in slice k
//            wr, wr_addr, wr_data             - general write port
//            pc_wr, pc_val                    - link write port
//            ready                            - 0 while the sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module zmips_regfile_mp
  import zmips_regfile_mp_pkg::*;
#(
  parameter  int W        = ZMIPS_XLEN,
  parameter  int DEPTH    = ZMIPS_NREG,
  parameter  int NRD      = 2,
  parameter  int LINK_REG = ZMIPS_LINK_REG,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  input  logic             wr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             pc_wr,
  input  logic [W-1:0]     pc_val,
  output logic             ready
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  rf_state_e       r_state;
  rf_state_e       w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [W-1:0]    r_mem [DEPTH];

  logic            w_clearing;
  logic            w_wr_in_range;
  logic            w_wr_commit;
  logic            w_pc_commit;

  // ready comes straight from the state flop, so it is a registered output.
  assign w_clearing = (r_state == RF_ST_CLEAR);
  assign ready      = (r_state == RF_ST_READY);

  // --------------------------------------------------------------------------
  // Sweep FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_ST_CLEAR: begin
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST_A) begin
          w_state_nxt = RF_ST_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RF_ST_READY: begin
        if (clr) begin
          w_state_nxt = RF_ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write-port arbitration. Writes are only honoured in READY; a general
  // write that collides with the link write on LINK_REG loses.
  // --------------------------------------------------------------------------
  assign w_wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign w_pc_commit   = ready && pc_wr && (LINK_A != '0);
  assign w_wr_commit   = ready && wr && (wr_addr != '0) && w_wr_in_range &&
                         !(pc_wr && (wr_addr == LINK_A));

  // Storage has no reset of its own: the sweep zeroes it and every read is
  // masked to 0 until the sweep completes. The async reset forces CLEAR, so
  // no write can land while rst_n is low.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr_commit) begin
        r_mem[wr_addr] <= wr_data;
      end
      if (w_pc_commit) begin
        r_mem[LINK_A] <= pc_val;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rdport
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_stored;

    assign w_addr = rd_addr[k*AW +: AW];
    // Out-of-range addresses may select garbage here; the port masks them.
    assign w_stored = r_mem[w_addr];

    zmips_regfile_rdport #(
      .W        (W),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .LINK_REG (LINK_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .clearing (w_clearing),
      .addr     (w_addr),
      .stored   (w_stored),
      .wr       (wr),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .pc_wr    (pc_wr),
      .pc_val   (pc_val),
      .data     (rd_data[k*W +: W])
    );
  end

endmodule : zmips_regfile_mp
`default_nettype wire

// File: tb/tb_zmips_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_zmips_regfile_mp
// Purpose  : Self-checking bench for zmips_regfile_mp. Three builds share the
//            clock and write buses: 4-port bypassing (main), 1-port without
//            bypass (nb) and a DEPTH=24 build (d24, link register 23).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zmips_regfile_mp;

  localparam int AW = 5;

  localparam int SRC_RDY_M = 4;
  localparam int SRC_NB    = 5;
  localparam int SRC_D     = 6;
  localparam int SRC_RDY_D = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            wr = 1'b0;
  logic            pc_wr = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [31:0]     wr_data = '0;
  logic [31:0]     pc_val = '0;

  logic [4*AW-1:0] rd_addr_m = '0;
  logic [4*32-1:0] rd_data_m;
  logic            ready_m;
  logic [AW-1:0]   rd_addr_nb = '0;
  logic [31:0]     rd_data_nb;
  logic            ready_nb;
  logic [AW-1:0]   rd_addr_d = '0;
  logic [31:0]     rd_data_d;
  logic            ready_d;

  always #5 clk = ~clk;

  zmips_regfile_mp #(.W(32), .DEPTH(32), .NRD(4), .LINK_REG(31), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_addr(rd_addr_m), .rd_data(rd_data_m),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_wr(pc_wr), .pc_val(pc_val),
    .ready(ready_m));

  zmips_regfile_mp #(.W(32), .DEPTH(32), .NRD(1), .LINK_REG(31), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_addr(rd_addr_nb), .rd_data(rd_data_nb),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_wr(pc_wr), .pc_val(pc_val),
    .ready(ready_nb));

  zmips_regfile_mp #(.W(32), .DEPTH(24), .NRD(1), .LINK_REG(23), .BYPASS(1)) u_dut_d24 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_wr(pc_wr), .pc_val(pc_val),
    .ready(ready_d));

  // --------------------------------------------------------------------------
  // Scoreboard and checking
  // --------------------------------------------------------------------------
  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int src);
    if (src < 4) return rd_data_m[src*32 +: 32];
    case (src)
      SRC_RDY_M: return {31'b0, ready_m};
      SRC_NB:    return rd_data_nb;
      SRC_D:     return rd_data_d;
      SRC_RDY_D: return {31'b0, ready_d};
      default:   return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int src, input logic [31:0] exp);
    sb_q.push_back('{tag, src, exp});
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_val(it.tag, observe(it.src), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic set_m(input int a0, input int a1, input int a2, input int a3);
    rd_addr_m = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Counts edges until each build reports ready; 0 means it never did.
  task automatic wait_ready(input int base, output int e_m, output int e_nb, output int e_d);
    e_m = 0; e_nb = 0; e_d = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (ready_m  && e_m  == 0) e_m  = base + n;
      if (ready_nb && e_nb == 0) e_nb = base + n;
      if (ready_d  && e_d  == 0) e_d  = base + n;
      if (e_m != 0 && e_nb != 0 && e_d != 0) break;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int e_m, e_nb, e_d;

    // Held in reset: everything reads 0, not ready.
    #12;
    set_m(7, 31, 0, 3);
    push("rst_low_p0", 0, 0);
    push("rst_low_p1", 1, 0);
    push("rst_low_rdy", SRC_RDY_M, 0);
    push("rst_low_rdy_d24", SRC_RDY_D, 0);
    drain();

    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(0, e_m, e_nb, e_d);
    check_val("rst_ready_edges", e_m, 32);
    check_val("rst_ready_edges_nb", e_nb, 32);
    check_val("rst_ready_edges_d24", e_d, 24);

    for (int b = 0; b < 32; b += 4) begin
      set_m(b, b + 1, b + 2, b + 3);
      for (int k = 0; k < 4; k++) push($sformatf("init_r%0d", b + k), k, 0);
      sample();
    end

    // Same-cycle write/read of r5: bypass vs no bypass.
    tick();
    wr = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    set_m(5, 0, 0, 0); rd_addr_nb = 5;
    push("byp_same_cycle", 0, 32'hDEADBEEF);
    push("nobyp_same_cycle", SRC_NB, 32'h0);
    sample();
    tick();
    wr = 1'b0;
    push("byp_next_cycle", 0, 32'hDEADBEEF);
    push("nobyp_next_cycle", SRC_NB, 32'hDEADBEEF);
    sample();

    // wr and pc_wr collide on r31: link value wins.
    tick();
    wr = 1'b1; wr_addr = 31; wr_data = 32'h1111;
    pc_wr = 1'b1; pc_val = 32'h0040_0008;
    set_m(31, 0, 0, 0); rd_addr_nb = 31;
    push("link_byp", 0, 32'h0040_0008);
    push("link_nobyp_old", SRC_NB, 32'h0);
    push("r0_read", 1, 32'h0);
    sample();
    tick();
    wr = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; pc_wr = 1'b0;
    push("link_stored", 0, 32'h0040_0008);
    push("link_stored_nb", SRC_NB, 32'h0040_0008);
    push("r0_wr_byp", 1, 32'h0);
    sample();

    // Simultaneous writes to different registers.
    tick();
    wr = 1'b1; wr_addr = 6; wr_data = 32'h66;
    pc_wr = 1'b1; pc_val = 32'h1234;
    set_m(6, 31, 0, 0);
    push("dual_wr_byp_r6", 0, 32'h66);
    push("dual_pc_byp_r31", 1, 32'h1234);
    push("dual_nobyp_r31", SRC_NB, 32'h0040_0008);
    sample();
    tick();
    wr = 1'b0; pc_wr = 1'b0;
    push("dual_r6", 0, 32'h66);
    push("dual_r31", 1, 32'h1234);
    push("r0_after_wr", 2, 32'h0);
    push("dual_r31_nb", SRC_NB, 32'h1234);
    sample();

    // Four independent ports.
    for (int i = 1; i <= 4; i++) begin
      tick();
      wr = 1'b1; wr_addr = AW'(i); wr_data = 32'(i);
    end
    tick();
    wr = 1'b0;
    set_m(4, 3, 2, 1);
    for (int k = 0; k < 4; k++) push($sformatf("mp_rev_p%0d", k), k, 32'(4 - k));
    sample();
    set_m(3, 3, 3, 3);
    for (int k = 0; k < 4; k++) push($sformatf("mp_same_p%0d", k), k, 32'd3);
    sample();

    // clr from READY, dropped write during sweep, restart at cnt=10.
    tick();
    wr = 1'b1; wr_addr = 7; wr_data = 32'hA5;
    tick();
    wr = 1'b0;
    set_m(7, 1, 2, 31);
    push("pre_clr_r7", 0, 32'hA5);
    push("pre_clr_r1", 1, 32'h1);
    push("pre_clr_r2", 2, 32'h2);
    push("pre_clr_r31", 3, 32'h1234);
    push("pre_clr_rdy", SRC_RDY_M, 1);
    sample();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wr = 1'b1; wr_addr = 7; wr_data = 32'h77;
    push("clr_rdy_drop", SRC_RDY_M, 0);
    push("clr_r7_zero", 0, 32'h0);
    push("clr_r1_zero", 1, 32'h0);
    drain();
    tick();
    wr = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    push("reclr_rdy", SRC_RDY_M, 0);
    drain();
    repeat (5) tick();
    wr = 1'b1; wr_addr = 2; wr_data = 32'h22;
    tick();
    wr = 1'b0;
    wait_ready(6, e_m, e_nb, e_d);
    check_val("reclr_ready_edges", e_m, 32);
    check_val("reclr_ready_edges_nb", e_nb, 32);
    check_val("reclr_ready_edges_d24", e_d, 24);
    set_m(7, 2, 1, 31);
    push("post_clr_r7", 0, 32'h0);
    push("post_clr_r2_dropped", 1, 32'h0);
    push("post_clr_r1", 2, 32'h0);
    push("post_clr_r31", 3, 32'h0);
    sample();

    // Reset mid-sweep and mid-write.
    tick();
    wr = 1'b1; wr_addr = 9; wr_data = 32'h99;
    tick();
    wr = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (15) tick();
    wr = 1'b1; wr_addr = 9; wr_data = 32'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    set_m(9, 5, 0, 31); rd_addr_nb = 5;
    for (int k = 0; k < 4; k++) push($sformatf("midrst_p%0d", k), k, 32'h0);
    push("midrst_nb", SRC_NB, 32'h0);
    push("midrst_rdy", SRC_RDY_M, 0);
    drain();
    tick();
    wr = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(0, e_m, e_nb, e_d);
    check_val("midrst_ready_edges", e_m, 32);
    check_val("midrst_ready_edges_nb", e_nb, 32);
    check_val("midrst_ready_edges_d24", e_d, 24);
    push("midrst_r9", 0, 32'h0);
    push("midrst_r5_nb", SRC_NB, 32'h0);
    sample();

    // DEPTH=24: out-of-range reads and writes, link register 23.
    tick();
    wr = 1'b1; wr_addr = 30; wr_data = 32'hABCD;
    rd_addr_d = 30;
    push("d24_oor_byp", SRC_D, 32'h0);
    push("d24_rdy", SRC_RDY_D, 1);
    sample();
    tick();
    wr_addr = 10; wr_data = 32'h10;
    push("d24_oor_stored", SRC_D, 32'h0);
    sample();
    tick();
    wr = 1'b0;
    pc_wr = 1'b1; pc_val = 32'hCAFE;
    rd_addr_d = 10;
    push("d24_r10", SRC_D, 32'h10);
    sample();
    tick();
    pc_wr = 1'b0;
    rd_addr_d = 23;
    push("d24_link_r23", SRC_D, 32'hCAFE);
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_zmips_regfile_mp
`default_nettype wire
